// File: rtl/rptr_empty_lvl.sv
// Read-side pointer and status block for the dual-clock FIFO.
// It keeps a binary and Gray read counter and decodes the synchronised write
// pointer back to binary. From these it derives the read fill level and the
// empty, almost-empty and sticky underflow flags, all registered in rclk.
module rptr_empty_lvl #(
  parameter int ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [ADDRSIZE:0]   ae_thresh,
  input  logic                runderflow_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic [ADDRSIZE:0] wbin_s;
  logic [ADDRSIZE:0] level_next;
  logic              rd_ok;
  logic              empty_next;
  logic              aempty_next;
  logic              uf_set;

  // Next-state arithmetic: pointer advance, write-pointer decode, level and flags
  always_comb begin
    rd_ok       = rinc & ~rempty;
    uf_set      = rinc & rempty;
    rbinnext    = rbin + {{ADDRSIZE{1'b0}}, rd_ok};
    rgraynext   = bin2gray(rbinnext);
    wbin_s      = gray2bin(rq2_wptr);
    // Modular difference; at most 2**ADDRSIZE for a healthy write side.
    level_next  = wbin_s - rbinnext;
    // Gray equality is the same condition as level_next == 0.
    empty_next  = (rgraynext == rq2_wptr);
    aempty_next = (level_next <= ae_thresh);
  end

  // Read pointer register: binary and Gray copies advance together
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin <= '0;
      rptr <= '0;
    end else begin
      rbin <= rbinnext;
      rptr <= rgraynext;
    end
  end

  // Status register: level, empty and almost-empty; empty resets asserted
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel  <= '0;
      rempty  <= 1'b1;
      raempty <= 1'b1;
    end else begin
      rlevel  <= level_next;
      rempty  <= empty_next;
      raempty <= aempty_next;
    end
  end

  // Sticky underflow: a new underflow takes priority over a clear
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      runderflow <= 1'b0;
    end else begin
      runderflow <= uf_set | (runderflow & ~runderflow_clr);
    end
  end

  assign raddr = rbin[ADDRSIZE-1:0];

endmodule
